// File: rtl/button_direction_ctrl.sv
// Per-button debouncer with one-cycle press pulses, feeding a snake direction
// register that queues the newest legal press and commits it on the game tick.
module button_direction_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] in,
  input  logic       step,
  output logic [3:0] press,
  output logic [1:0] dir,
  output logic       pend_valid
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]         lvl;
  logic [3:0][CW-1:0] cnt_q, cnt_d;
  logic [3:0]         stable_q, stable_d;
  logic [3:0]         press_q, press_d;
  logic [1:0]         dir_q, dir_d;
  logic [1:0]         pend_q, pend_d;
  logic               pend_valid_q, pend_valid_d;
  logic [1:0]         cand;
  logic [1:0]         refDir;
  logic               accept;

  assign lvl = ACTIVE_LOW ? ~in : in;

  // A lane flips only after the new level is sampled DEBOUNCE_CYCLES times in a row;
  // the pulse is raised in the same edge the stable level goes high.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_d[i]    = '0;
      stable_d[i] = stable_q[i];
      press_d[i]  = 1'b0;
      if (lvl[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stable_d[i] = lvl[i];
          press_d[i]  = lvl[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    cand = 2'd0;
    if (press_q[0])      cand = 2'd0;
    else if (press_q[1]) cand = 2'd1;
    else if (press_q[2]) cand = 2'd2;
    else if (press_q[3]) cand = 2'd3;
  end

  // Reversal is judged against the direction that will be in force after this edge,
  // so a press arriving with the tick cannot undo the move being committed.
  always_comb begin
    refDir       = (step && pend_valid_q) ? pend_q : dir_q;
    accept       = (press_q != 4'b0000) && (cand != (refDir ^ 2'b10));
    dir_d        = refDir;
    pend_d       = accept ? cand : pend_q;
    pend_valid_d = accept | (pend_valid_q & ~step);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      stable_q     <= '0;
      press_q      <= '0;
      dir_q        <= 2'b00;
      pend_q       <= 2'b00;
      pend_valid_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      stable_q     <= stable_d;
      press_q      <= press_d;
      dir_q        <= dir_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  assign press      = press_q;
  assign dir        = dir_q;
  assign pend_valid = pend_valid_q;

endmodule

// File: tb/tb_button_direction_ctrl.sv
// Scoreboard bench for button_direction_ctrl: two instances (active-high and
// active-low inputs, 4-cycle debounce) driven with hand-computed directed vectors.
module tb_button_direction_ctrl;

  typedef struct {
    int         cyc;
    logic [3:0] press;
    logic [1:0] dir;
    logic       pv;
    string      name;
  } exp_t;

  logic clk = 1'b0;
  int   cyc = 0;

  logic       resetA, stepA, pvA;
  logic [3:0] inA, pressA;
  logic [1:0] dirA;
  logic       resetB, stepB, pvB;
  logic [3:0] inB, pressB;
  logic [1:0] dirB;

  exp_t qA[$];
  exp_t qB[$];
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  button_direction_ctrl #(.DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b0)) dutA (
    .clk(clk), .reset(resetA), .in(inA), .step(stepA),
    .press(pressA), .dir(dirA), .pend_valid(pvA)
  );

  button_direction_ctrl #(.DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b1)) dutB (
    .clk(clk), .reset(resetB), .in(inB), .step(stepB),
    .press(pressB), .dir(dirB), .pend_valid(pvB)
  );

  task automatic checkOutput(input exp_t e, input logic [3:0] p, input logic [1:0] d,
                             input logic v, input string who);
    checks++;
    if (p === e.press && d === e.dir && v === e.pv) passes++;
    else $display("[TB] FAIL %s_%s edge %0d: got press=%b dir=%b pend_valid=%b, want press=%b dir=%b pend_valid=%b",
                  who, e.name, e.cyc, p, d, v, e.press, e.dir, e.pv);
  endtask

  // Monitor: outputs are sampled mid-cycle and matched against queued expectations.
  always @(negedge clk) begin
    while (qA.size() != 0 && qA[0].cyc <= cyc) checkOutput(qA.pop_front(), pressA, dirA, pvA, "A");
    while (qB.size() != 0 && qB[0].cyc <= cyc) checkOutput(qB.pop_front(), pressB, dirB, pvB, "B");
  end

  task automatic applyStimulus(input bit sel, input logic rst, input logic [3:0] iv, input logic st);
    if (sel) begin
      resetB = rst; inB = iv; stepB = st;
    end else begin
      resetA = rst; inA = iv; stepA = st;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cycleStep(input bit sel, input logic rst, input logic [3:0] iv, input logic st,
                           input logic [3:0] ep, input logic [1:0] ed, input logic ev,
                           input string nm);
    exp_t e;
    applyStimulus(sel, rst, iv, st);
    e.cyc = cyc; e.press = ep; e.dir = ed; e.pv = ev; e.name = nm;
    if (sel) qB.push_back(e);
    else qA.push_back(e);
  endtask

  task automatic holdIn(input bit sel, input logic [3:0] iv, input int n, input logic [3:0] lastPress,
                        input logic [1:0] ed, input logic ev, input string nm);
    for (int i = 1; i <= n; i++)
      cycleStep(sel, 1'b0, iv, 1'b0, (i == n) ? lastPress : 4'b0000, ed, ev, nm);
  endtask

  initial begin
    resetA = 1'b1; inA = 4'b0000; stepA = 1'b0;
    resetB = 1'b1; inB = 4'b1111; stepB = 1'b0;

    // Reset state and quiet idle.
    cycleStep(0, 1, 4'b0000, 0, 4'b0000, 2'b00, 0, "reset");
    holdIn(0, 4'b0000, 20, 4'b0000, 2'b00, 0, "idle");

    // Glitching input never settles; a clean hold pulses once on the 4th edge.
    for (int i = 0; i < 6; i++)
      cycleStep(0, 0, (i % 2 == 0) ? 4'b0010 : 4'b0000, 0, 4'b0000, 2'b00, 0, "glitch");
    for (int h = 1; h <= 10; h++)
      cycleStep(0, 0, 4'b0010, 0, (h == 4) ? 4'b0010 : 4'b0000, 2'b00, (h >= 5) ? 1'b1 : 1'b0, "hold");
    holdIn(0, 4'b0000, 6, 4'b0000, 2'b00, 1, "release");

    // Up is accepted and committed; left from right is a reversal.
    cycleStep(0, 1, 4'b0000, 0, 4'b0000, 2'b00, 0, "reset3");
    holdIn(0, 4'b0010, 4, 4'b0010, 2'b00, 0, "up_press");
    cycleStep(0, 0, 4'b0000, 0, 4'b0000, 2'b00, 1, "up_pend");
    cycleStep(0, 0, 4'b0000, 1, 4'b0000, 2'b01, 0, "up_commit");
    holdIn(0, 4'b0000, 4, 4'b0000, 2'b01, 0, "up_idle");
    cycleStep(0, 1, 4'b0000, 0, 4'b0000, 2'b00, 0, "reset3b");
    holdIn(0, 4'b0100, 4, 4'b0100, 2'b00, 0, "left_press");
    cycleStep(0, 0, 4'b0000, 0, 4'b0000, 2'b00, 0, "left_reject");
    cycleStep(0, 0, 4'b0000, 1, 4'b0000, 2'b00, 0, "left_step");
    holdIn(0, 4'b0000, 3, 4'b0000, 2'b00, 0, "left_idle");

    // Simultaneous presses: lowest index wins; a later legal press overwrites pending.
    cycleStep(0, 1, 4'b0000, 0, 4'b0000, 2'b00, 0, "reset4");
    holdIn(0, 4'b1010, 4, 4'b1010, 2'b00, 0, "dual_press");
    cycleStep(0, 0, 4'b1010, 0, 4'b0000, 2'b00, 1, "dual_pend");
    holdIn(0, 4'b0000, 4, 4'b0000, 2'b00, 1, "dual_release");
    holdIn(0, 4'b1000, 4, 4'b1000, 2'b00, 1, "down_press");
    cycleStep(0, 0, 4'b0000, 0, 4'b0000, 2'b00, 1, "down_pend");
    cycleStep(0, 0, 4'b0000, 1, 4'b0000, 2'b11, 0, "down_commit");
    holdIn(0, 4'b0000, 2, 4'b0000, 2'b11, 0, "down_idle");
    holdIn(0, 4'b1001, 4, 4'b1001, 2'b11, 0, "rd_press");
    cycleStep(0, 0, 4'b0000, 0, 4'b0000, 2'b11, 1, "rd_pend");
    cycleStep(0, 0, 4'b0000, 1, 4'b0000, 2'b00, 0, "rd_commit");
    holdIn(0, 4'b0000, 2, 4'b0000, 2'b00, 0, "rd_idle");

    // Press landing in the step cycle is judged against the newly committed direction.
    cycleStep(0, 1, 4'b0000, 0, 4'b0000, 2'b00, 0, "reset5");
    holdIn(0, 4'b0010, 4, 4'b0010, 2'b00, 0, "s5_up");
    cycleStep(0, 0, 4'b0000, 0, 4'b0000, 2'b00, 1, "s5_up_pend");
    holdIn(0, 4'b0000, 3, 4'b0000, 2'b00, 1, "s5_idle");
    holdIn(0, 4'b1000, 4, 4'b1000, 2'b00, 1, "s5_down");
    cycleStep(0, 0, 4'b0000, 1, 4'b0000, 2'b01, 0, "s5_down_reject");
    holdIn(0, 4'b0000, 3, 4'b0000, 2'b01, 0, "s5_idle2");
    holdIn(0, 4'b0010, 4, 4'b0010, 2'b01, 0, "s5_up2");
    cycleStep(0, 0, 4'b0000, 0, 4'b0000, 2'b01, 1, "s5_up2_pend");
    holdIn(0, 4'b0000, 3, 4'b0000, 2'b01, 1, "s5_idle3");
    holdIn(0, 4'b0001, 4, 4'b0001, 2'b01, 1, "s5_right");
    cycleStep(0, 0, 4'b0000, 1, 4'b0000, 2'b01, 1, "s5_right_accept");
    holdIn(0, 4'b0000, 3, 4'b0000, 2'b01, 1, "s5_idle4");
    cycleStep(0, 0, 4'b0000, 1, 4'b0000, 2'b00, 0, "s5_right_commit");

    // Active-low lane: reset mid-debounce discards the partial count.
    holdIn(1, 4'b1111, 5, 4'b0000, 2'b00, 0, "al_idle");
    holdIn(1, 4'b1110, 3, 4'b0000, 2'b00, 0, "al_partial");
    cycleStep(1, 1, 4'b1110, 0, 4'b0000, 2'b00, 0, "al_reset");
    holdIn(1, 4'b1110, 4, 4'b0001, 2'b00, 0, "al_press");
    cycleStep(1, 0, 4'b1110, 0, 4'b0000, 2'b00, 1, "al_pend");
    cycleStep(1, 0, 4'b1111, 1, 4'b0000, 2'b00, 0, "al_commit");

    for (int i = 0; i < 10 && (qA.size() != 0 || qB.size() != 0); i++) @(negedge clk);
    #1;
    if (qA.size() != 0 || qB.size() != 0) begin
      checks++;
      $display("[TB] FAIL drain: %0d expectations left, want 0", qA.size() + qB.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
